// File: rtl/axi_lite_write_slave.sv
// AXI4-Lite write-only slave: collects AW and W independently, commits into a
// small register bank, and answers on B. One transaction in flight at a time.
`timescale 1ns/1ps
module axi_lite_write_slave #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 16
) (
  input  logic                        ACLK,
  input  logic                        ARESETn,
  input  logic                        AWVALID,
  output logic                        AWREADY,
  input  logic [ADDR_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                  AWPROT,
  input  logic                        WVALID,
  output logic                        WREADY,
  input  logic [DATA_WIDTH-1:0]       WDATA,
  input  logic [3:0]                  WSTRB,
  output logic                        BVALID,
  input  logic                        BREADY,
  output logic [1:0]                  BRESP,
  input  logic [$clog2(NUM_REGS)-1:0] dbg_idx,
  output logic [DATA_WIDTH-1:0]       dbg_data
);

  localparam int IDX_W = $clog2(NUM_REGS);

  typedef enum logic [1:0] {
    ST_ACCEPT = 2'd0,
    ST_COMMIT = 2'd1,
    ST_RESP   = 2'd2
  } state_e;

  state_e                  state_q, state_d;
  logic                    awready_q, awready_d;
  logic                    wready_q, wready_d;
  logic                    bvalid_q, bvalid_d;
  logic [1:0]              bresp_q, bresp_d;
  logic                    aw_full_q, aw_full_d;
  logic                    w_full_q, w_full_d;
  logic [ADDR_WIDTH-1:0]   awaddr_q, awaddr_d;
  logic                    awpriv_q, awpriv_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [3:0]              wstrb_q, wstrb_d;
  logic [DATA_WIDTH-1:0]   regs_q [NUM_REGS];
  logic [DATA_WIDTH-1:0]   regs_d [NUM_REGS];

  logic [IDX_W-1:0]        idx_s;
  logic                    slverr_s;
  logic                    unused_prot;

  // Only the privileged bit of AWPROT matters to this slave.
  assign unused_prot = &{1'b0, AWPROT[2:1]};

  // Address decode of the latched AW: alignment, range and reg0 privilege.
  always_comb begin
    idx_s    = awaddr_q[IDX_W+1:2];
    slverr_s = 1'b0;
    if (awaddr_q[1:0] != 2'b00) begin
      slverr_s = 1'b1;
    end else if (|awaddr_q[ADDR_WIDTH-1:IDX_W+2]) begin
      slverr_s = 1'b1;
    end else if ((idx_s == {IDX_W{1'b0}}) && !awpriv_q) begin
      slverr_s = 1'b1;
    end else begin
      slverr_s = 1'b0;
    end
  end

  // Next-state and channel control.
  always_comb begin
    state_d   = state_q;
    awready_d = awready_q;
    wready_d  = wready_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    aw_full_d = aw_full_q;
    w_full_d  = w_full_q;
    awaddr_d  = awaddr_q;
    awpriv_d  = awpriv_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    regs_d    = regs_q;

    case (state_q)
      ST_ACCEPT: begin
        // Ready rises on the first edge out of reset because the flag is clear.
        if (AWVALID && awready_q) begin
          awaddr_d  = AWADDR;
          awpriv_d  = AWPROT[0];
          aw_full_d = 1'b1;
          awready_d = 1'b0;
        end else begin
          awready_d = !aw_full_q;
        end
        if (WVALID && wready_q) begin
          wdata_d  = WDATA;
          wstrb_d  = WSTRB;
          w_full_d = 1'b1;
          wready_d = 1'b0;
        end else begin
          wready_d = !w_full_q;
        end
        if (aw_full_d && w_full_d) begin
          state_d = ST_COMMIT;
        end else begin
          state_d = ST_ACCEPT;
        end
      end
      ST_COMMIT: begin
        bvalid_d = 1'b1;
        bresp_d  = slverr_s ? 2'b10 : 2'b00;
        for (int k = 0; k < 4; k++) begin
          regs_d[idx_s][8*k +: 8] = (wstrb_q[k] && !slverr_s) ?
                                    wdata_q[8*k +: 8] : regs_q[idx_s][8*k +: 8];
        end
        state_d = ST_RESP;
      end
      ST_RESP: begin
        if (BREADY) begin
          bvalid_d  = 1'b0;
          aw_full_d = 1'b0;
          w_full_d  = 1'b0;
          awready_d = 1'b1;
          wready_d  = 1'b1;
          state_d   = ST_ACCEPT;
        end else begin
          state_d = ST_RESP;
        end
      end
      default: begin
        state_d = ST_ACCEPT;
      end
    endcase
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge ACLK) begin
    if (!ARESETn) begin
      state_q   <= ST_ACCEPT;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= 2'b00;
      aw_full_q <= 1'b0;
      w_full_q  <= 1'b0;
      awaddr_q  <= {ADDR_WIDTH{1'b0}};
      awpriv_q  <= 1'b0;
      wdata_q   <= {DATA_WIDTH{1'b0}};
      wstrb_q   <= 4'b0000;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= {DATA_WIDTH{1'b0}};
      end
    end else begin
      state_q   <= state_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      aw_full_q <= aw_full_d;
      w_full_q  <= w_full_d;
      awaddr_q  <= awaddr_d;
      awpriv_q  <= awpriv_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  assign AWREADY  = awready_q;
  assign WREADY   = wready_q;
  assign BVALID   = bvalid_q;
  assign BRESP    = bresp_q;
  assign dbg_data = regs_q[dbg_idx];

endmodule

// File: tb/tb_axi_lite_write_slave.sv
// Directed self-checking bench for axi_lite_write_slave; inputs change and
// outputs are sampled on the falling clock edge.
`timescale 1ns/1ps
module tb_axi_lite_write_slave;

  logic        ACLK;
  logic        ARESETn;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] AWADDR;
  logic [2:0]  AWPROT;
  logic        WVALID;
  logic        WREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        BVALID;
  logic        BREADY;
  logic [1:0]  BRESP;
  logic [3:0]  dbg_idx;
  logic [31:0] dbg_data;

  int          checks;
  int          errors;
  logic [31:0] model [16];

  axi_lite_write_slave #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .NUM_REGS  (16)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .AWADDR  (AWADDR),
    .AWPROT  (AWPROT),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .BRESP   (BRESP),
    .dbg_idx (dbg_idx),
    .dbg_data(dbg_data)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_write(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) model[addr[5:2]][8*k +: 8] = data[8*k +: 8];
    end
  endtask

  // Walks every register through dbg_idx; ends back on a falling edge.
  task automatic check_bank(input string tag);
    for (int i = 0; i < 16; i++) begin
      dbg_idx = 4'(i);
      #1;
      check_eq(tag, dbg_data, model[i]);
    end
    @(negedge ACLK);
  endtask

  // AW and W presented together with BREADY high; expects the 3-cycle sequence.
  task automatic write_txn(input logic [31:0] addr, input logic [2:0] prot, input logic [31:0] data,
                           input logic [3:0] strb, input logic [1:0] exp_resp, input string tag);
    AWADDR = addr; AWPROT = prot; AWVALID = 1'b1;
    WDATA = data; WSTRB = strb; WVALID = 1'b1; BREADY = 1'b1;
    @(negedge ACLK);
    check_eq({tag, "_awready_low"}, 32'(AWREADY), 32'd0);
    check_eq({tag, "_wready_low"}, 32'(WREADY), 32'd0);
    check_eq({tag, "_no_early_b"}, 32'(BVALID), 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_eq({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check_eq({tag, "_bresp"}, 32'(BRESP), 32'(exp_resp));
    @(negedge ACLK);
    check_eq({tag, "_bvalid_drop"}, 32'(BVALID), 32'd0);
    check_eq({tag, "_awready_back"}, 32'(AWREADY), 32'd1);
    check_eq({tag, "_wready_back"}, 32'(WREADY), 32'd1);
    if (exp_resp == 2'b00) model_write(addr, data, strb);
  endtask

  // One channel, then the other four edges later.
  task automatic write_split(input logic aw_first, input logic [31:0] addr, input logic [31:0] data, input string tag);
    AWADDR = addr; AWPROT = 3'b001; WDATA = data; WSTRB = 4'hF; BREADY = 1'b1;
    if (aw_first) AWVALID = 1'b1; else WVALID = 1'b1;
    @(negedge ACLK);
    check_eq({tag, "_first_ready"}, 32'(aw_first ? AWREADY : WREADY), 32'd0);
    check_eq({tag, "_other_ready"}, 32'(aw_first ? WREADY : AWREADY), 32'd1);
    AWVALID = 1'b0; WVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge ACLK);
      check_eq({tag, "_wait_no_b"}, 32'(BVALID), 32'd0);
    end
    if (aw_first) WVALID = 1'b1; else AWVALID = 1'b1;
    @(negedge ACLK);
    check_eq({tag, "_commit_no_b"}, 32'(BVALID), 32'd0);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_eq({tag, "_bvalid"}, 32'(BVALID), 32'd1);
    check_eq({tag, "_bresp"}, 32'(BRESP), 32'd0);
    @(negedge ACLK);
    check_eq({tag, "_bvalid_drop"}, 32'(BVALID), 32'd0);
    model_write(addr, data, 4'hF);
  endtask

  initial begin
    checks = 0; errors = 0;
    ARESETn = 1'b0; AWVALID = 1'b0; AWADDR = 32'h0; AWPROT = 3'b000;
    WVALID = 1'b0; WDATA = 32'h0; WSTRB = 4'h0; BREADY = 1'b0; dbg_idx = 4'h0;
    for (int i = 0; i < 16; i++) model[i] = 32'h0;

    repeat (2) @(negedge ACLK);
    check_eq("rst_awready", 32'(AWREADY), 32'd0);
    check_eq("rst_wready", 32'(WREADY), 32'd0);
    check_eq("rst_bvalid", 32'(BVALID), 32'd0);
    check_eq("rst_bresp", 32'(BRESP), 32'd0);
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_eq("rel_awready", 32'(AWREADY), 32'd1);
    check_eq("rel_wready", 32'(WREADY), 32'd1);

    write_txn(32'h4, 3'b000, 32'hDEADBEEF, 4'hF, 2'b00, "simul");
    check_bank("bank_simul");

    write_split(1'b1, 32'h8, 32'h12345678, "aw_first");
    write_split(1'b0, 32'h14, 32'hA5A55A5A, "w_first");
    check_bank("bank_split");

    write_txn(32'hC, 3'b000, 32'hFFFFFFFF, 4'hF, 2'b00, "fill3");
    write_txn(32'hC, 3'b000, 32'h00000000, 4'b0101, 2'b00, "strb");
    check_eq("strb_model", model[3], 32'hFF00FF00);
    write_txn(32'h24, 3'b000, 32'h99999999, 4'b0000, 2'b00, "strb_none");
    check_bank("bank_strb");

    write_txn(32'h40, 3'b001, 32'hCAFEF00D, 4'hF, 2'b10, "err_range");
    write_txn(32'h6, 3'b001, 32'hCAFEF00D, 4'hF, 2'b10, "err_align");
    write_txn(32'h0, 3'b000, 32'hCAFEF00D, 4'hF, 2'b10, "err_priv");
    write_txn(32'h0, 3'b110, 32'hCAFEF00D, 4'hF, 2'b10, "err_priv_hi");
    check_bank("bank_err");
    write_txn(32'h0, 3'b001, 32'h0BADF00D, 4'hF, 2'b00, "priv_ok");
    check_bank("bank_priv");

    // Backpressure: an erroring write held in RESP while the next AW waits.
    AWADDR = 32'h44; AWPROT = 3'b001; AWVALID = 1'b1;
    WDATA = 32'h11111111; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge ACLK);
    check_eq("bp_aw_taken", 32'(AWREADY), 32'd0);
    AWADDR = 32'h1C; WVALID = 1'b0;
    @(negedge ACLK);
    check_eq("bp_bvalid", 32'(BVALID), 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge ACLK);
      check_eq("bp_bvalid_hold", 32'(BVALID), 32'd1);
      check_eq("bp_bresp_hold", 32'(BRESP), 32'd2);
      check_eq("bp_awready_low", 32'(AWREADY), 32'd0);
      check_eq("bp_wready_low", 32'(WREADY), 32'd0);
    end
    BREADY = 1'b1;
    @(negedge ACLK);
    check_eq("bp_hs_bvalid", 32'(BVALID), 32'd0);
    check_eq("bp_hs_awready", 32'(AWREADY), 32'd1);
    check_eq("bp_hs_wready", 32'(WREADY), 32'd1);
    @(negedge ACLK);
    check_eq("bp_new_aw_taken", 32'(AWREADY), 32'd0);
    check_eq("bp_new_w_open", 32'(WREADY), 32'd1);
    AWVALID = 1'b0; WDATA = 32'h00000077; WSTRB = 4'hF; WVALID = 1'b1;
    @(negedge ACLK);
    check_eq("bp_w_taken", 32'(WREADY), 32'd0);
    check_eq("bp_w_no_b", 32'(BVALID), 32'd0);
    WVALID = 1'b0;
    @(negedge ACLK);
    check_eq("bp2_bvalid", 32'(BVALID), 32'd1);
    check_eq("bp2_bresp", 32'(BRESP), 32'd0);
    @(negedge ACLK);
    check_eq("bp2_bvalid_drop", 32'(BVALID), 32'd0);
    model_write(32'h1C, 32'h00000077, 4'hF);
    check_bank("bank_bp");

    // Reset while a response is pending.
    AWADDR = 32'h10; AWPROT = 3'b001; AWVALID = 1'b1;
    WDATA = 32'h55AA55AA; WSTRB = 4'hF; WVALID = 1'b1; BREADY = 1'b0;
    @(negedge ACLK);
    AWVALID = 1'b0; WVALID = 1'b0;
    @(negedge ACLK);
    check_eq("mid_bvalid", 32'(BVALID), 32'd1);
    ARESETn = 1'b0;
    @(negedge ACLK);
    check_eq("mid_rst_bvalid", 32'(BVALID), 32'd0);
    check_eq("mid_rst_bresp", 32'(BRESP), 32'd0);
    check_eq("mid_rst_awready", 32'(AWREADY), 32'd0);
    check_eq("mid_rst_wready", 32'(WREADY), 32'd0);
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    check_bank("bank_mid_rst");
    BREADY = 1'b1;
    ARESETn = 1'b1;
    @(negedge ACLK);
    check_eq("mid_rel_awready", 32'(AWREADY), 32'd1);
    check_eq("mid_rel_wready", 32'(WREADY), 32'd1);
    check_eq("mid_rel_bvalid", 32'(BVALID), 32'd0);
    write_txn(32'h3C, 3'b000, 32'h01020304, 4'hF, 2'b00, "post_rst");
    check_bank("bank_final");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
